// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MAR/MBR memory-access unit. It holds the address register (MAR) and the
//   data register (MBR), and runs one read or write transaction at a time on
//   a req/ack memory port of variable latency. It reports the end of each
//   transaction to the control unit with a one-cycle mfc pulse (success) or
//   err pulse (no ack within TIMEOUT request cycles).
//
// Parameters
//   DW       data width (bus, MBR, memory data)
//   AW       address width (MAR, memory address), AW <= DW
//   TIMEOUT  max mem_req cycles without mem_ack before abort, 0 = never
//
// Ports
//   CLK, RST   clock (rising edge), asynchronous active-high reset
//   mar_in     load MAR from bus_in[AW-1:0] (idle only)
//   mbr_in     load MBR from bus_in (idle only)
//   wmfc       start a transaction (idle only), rnw selects read (1) / write (0)
//   bus_in     internal data bus
//   mbr_data   MBR contents
//   busy       transaction in progress
//   mfc / err  one-cycle completion / timeout pulses
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack : memory port
module mem_access_unit #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          mar_in,
  input  logic          mbr_in,
  input  logic          wmfc,
  input  logic          rnw,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] mbr_data,
  output logic          busy,
  output logic          mfc,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  // The counter only has to reach TIMEOUT-1; the FSM leaves REQ before it
  // could wrap. A zero TIMEOUT still gets a one-bit (idle) counter.
  localparam int CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST     = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   mar_q, mar_d;
  logic [DW-1:0]   mbr_q, mbr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rnw_q, rnw_d;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    case (state_q)
      S_IDLE: begin
        // Loads and start share the same edge, so a transaction started
        // together with a load already uses the new MAR/MBR.
        if (mar_in) mar_d = bus_in[AW-1:0];
        if (mbr_in) mbr_d = bus_in;
        if (wmfc) begin
          state_d = S_REQ;
          rnw_d   = rnw;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = S_DONE;
          if (rnw_q) mbr_d = mem_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mbr_q   <= '0;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
    end
  end

  // Outputs are decoded from registered state only, so reset clears them
  // immediately without waiting for a clock edge.
  assign busy      = (state_q != S_IDLE);
  assign mfc       = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = (state_q == S_REQ) && !rnw_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mbr_q;
  assign mbr_data  = mbr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       mar_in, mbr_in, wmfc, rnw;
  logic [7:0] bus_in;
  logic [7:0] mbr_data;
  logic       busy, mfc, err, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] mbr;
    logic [7:0] addr;
    logic       we;
    int         req_cycles;
  } exp_t;
  exp_t sb[$];

  mem_access_unit #(.DW(8), .AW(8), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .mar_in(mar_in), .mbr_in(mbr_in), .wmfc(wmfc),
    .rnw(rnw), .bus_in(bus_in), .mbr_data(mbr_data), .busy(busy), .mfc(mfc),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  // Memory responder and observer. Runs from just after a start request until
  // mfc/err is seen (bounded), then watches 'tail' further cycles for stray
  // pulses or requests. Acks in request cycle ack_at (0 = never). In request
  // cycle poke_at it drives a busy-time mar_in/wmfc attempt.
  task automatic wait_done(input int ack_at, input logic [7:0] rdata,
                           input int poke_at, input int tail,
                           output int req_cycles, output int n_mfc,
                           output int n_err, output int done_cyc,
                           output logic [7:0] addr_seen, output logic we_seen,
                           output logic [7:0] wdata_seen);
    int cyc = 0;
    bit done = 0;
    req_cycles = 0; n_mfc = 0; n_err = 0; done_cyc = -1;
    addr_seen = 8'h00; we_seen = 1'b0; wdata_seen = 8'h00;
    while (!done && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      wmfc = 1'b0; mar_in = 1'b0; mbr_in = 1'b0; mem_ack = 1'b0;
      if (mfc) begin n_mfc++; done_cyc = cyc; done = 1; end
      if (err) begin n_err++; done_cyc = cyc; done = 1; end
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          addr_seen = mem_addr; we_seen = mem_we; wdata_seen = mem_wdata;
        end
        if (req_cycles == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
        if (req_cycles == poke_at) begin
          mar_in = 1'b1; bus_in = 8'hFF; wmfc = 1'b1; rnw = 1'b0;
        end
      end
    end
    for (int i = 0; i < tail; i++) begin
      @(negedge CLK);
      wmfc = 1'b0; mar_in = 1'b0; mem_ack = 1'b0;
      if (mfc) n_mfc++;
      if (err) n_err++;
      if (mem_req) req_cycles++;
    end
  endtask

  task automatic load_mar(input logic [7:0] v);
    mar_in = 1'b1; bus_in = v;
    @(negedge CLK);
    mar_in = 1'b0;
  endtask

  task automatic load_mbr(input logic [7:0] v);
    mbr_in = 1'b1; bus_in = v;
    @(negedge CLK);
    mbr_in = 1'b0;
  endtask

  // Runs one transaction already requested (wmfc set) and compares it against
  // the scoreboard entry pushed by the caller.
  task automatic run_and_score(input string name, input int ack_at,
                               input logic [7:0] rdata, input int poke_at,
                               input int tail, input int exp_done_cyc);
    int rq, nm, ne, dc;
    logic [7:0] a, wd;
    logic w;
    exp_t e;
    wait_done(ack_at, rdata, poke_at, tail, rq, nm, ne, dc, a, w, wd);
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: scoreboard empty at completion", name);
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (nm !== (e.is_err ? 0 : 1)) begin
      miscompares++; $display("FAIL %s mfc_count: got %0d expected %0d", name, nm, e.is_err ? 0 : 1);
    end
    vectors++;
    if (ne !== (e.is_err ? 1 : 0)) begin
      miscompares++; $display("FAIL %s err_count: got %0d expected %0d", name, ne, e.is_err ? 1 : 0);
    end
    vectors++;
    if (rq !== e.req_cycles) begin
      miscompares++; $display("FAIL %s req_cycles: got %0d expected %0d", name, rq, e.req_cycles);
    end
    vectors++;
    if (a !== e.addr) begin
      miscompares++; $display("FAIL %s mem_addr: got %h expected %h", name, a, e.addr);
    end
    vectors++;
    if (w !== e.we) begin
      miscompares++; $display("FAIL %s mem_we: got %b expected %b", name, w, e.we);
    end
    vectors++;
    if (mbr_data !== e.mbr) begin
      miscompares++; $display("FAIL %s mbr_data: got %h expected %h", name, mbr_data, e.mbr);
    end
    if (e.we) begin
      vectors++;
      if (wd !== e.mbr) begin
        miscompares++; $display("FAIL %s mem_wdata: got %h expected %h", name, wd, e.mbr);
      end
    end
    vectors++;
    if (dc !== exp_done_cyc) begin
      miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, dc, exp_done_cyc);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy, mfc, err, mem_req, mem_we, mem_addr, mbr_data} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy%b mfc%b err%b req%b we%b addr%h mbr%h expected all 0",
               busy, mfc, err, mem_req, mem_we, mem_addr, mbr_data);
    end
    load_mar(8'h3C);
    load_mbr(8'h77);
    vectors++;
    if ({mem_addr, mbr_data} !== 16'h3C77) begin
      miscompares++; $display("FAIL idle_load: got %h%h expected 3c77", mem_addr, mbr_data);
    end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({mem_addr, mbr_data, busy, mem_req} !== 18'd0) begin
      miscompares++; $display("FAIL async_reset: got addr%h mbr%h busy%b req%b expected 0", mem_addr, mbr_data, busy, mem_req);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_read();
    load_mar(8'h3C);
    rnw = 1'b1; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'hA5, addr: 8'h3C, we: 1'b0, req_cycles: 3});
    run_and_score("read", 3, 8'hA5, 0, 4, 4);
  endtask

  task automatic test_write();
    load_mar(8'h10);
    mbr_in = 1'b1; bus_in = 8'h5A; rnw = 1'b0; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'h5A, addr: 8'h10, we: 1'b1, req_cycles: 1});
    run_and_score("write", 1, 8'hEE, 0, 4, 2);
  endtask

  task automatic test_timeout();
    load_mar(8'h81);
    rnw = 1'b1; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b1, mbr: 8'h5A, addr: 8'h81, we: 1'b0, req_cycles: 15});
    run_and_score("timeout", 0, 8'h00, 0, 4, 16);
    load_mar(8'h82);
    rnw = 1'b1; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'hC3, addr: 8'h82, we: 1'b0, req_cycles: 15});
    run_and_score("ack_last_cycle", 15, 8'hC3, 0, 4, 16);
  endtask

  task automatic test_busy_guard();
    load_mar(8'h20);
    rnw = 1'b1; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'h11, addr: 8'h20, we: 1'b0, req_cycles: 4});
    run_and_score("busy_guard", 4, 8'h11, 2, 6, 5);
    vectors++;
    if (mem_addr !== 8'h20) begin
      miscompares++; $display("FAIL busy_guard_mar: got %h expected 20", mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    load_mar(8'h31);
    rnw = 1'b1; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'h42, addr: 8'h31, we: 1'b0, req_cycles: 2});
    run_and_score("b2b_first", 2, 8'h42, 0, 0, 3);
    // Stray ack while IDLE must be ignored; start the next one right away.
    @(negedge CLK);
    mem_ack = 1'b1;
    mar_in = 1'b1; bus_in = 8'h32; rnw = 1'b0; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'h42, addr: 8'h32, we: 1'b1, req_cycles: 1});
    run_and_score("b2b_second", 1, 8'h00, 0, 4, 2);
  endtask

  task automatic test_reset_in_req();
    load_mar(8'h44);
    rnw = 1'b1; wmfc = 1'b1;
    @(negedge CLK);
    wmfc = 1'b0;
    @(negedge CLK);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_req_pre: mem_req got %b expected 1", mem_req);
    end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({mem_req, mfc, err, busy, mbr_data, mem_addr} !== 20'd0) begin
      miscompares++; $display("FAIL rst_in_req: got req%b mfc%b err%b busy%b mbr%h addr%h expected 0",
                              mem_req, mfc, err, busy, mbr_data, mem_addr);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({busy, mfc, err} !== 3'b000) begin
      miscompares++; $display("FAIL rst_release_idle: got busy%b mfc%b err%b expected 000", busy, mfc, err);
    end
    load_mar(8'h5C);
    rnw = 1'b1; wmfc = 1'b1;
    sb.push_back('{is_err: 1'b0, mbr: 8'h96, addr: 8'h5C, we: 1'b0, req_cycles: 2});
    run_and_score("read_after_rst", 2, 8'h96, 0, 4, 3);
  endtask

  initial begin
    RST = 1'b1;
    mar_in = 1'b0; mbr_in = 1'b0; wmfc = 1'b0; rnw = 1'b0;
    bus_in = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_busy_guard();
    test_back_to_back();
    test_reset_in_req();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
